// File: rtl/iiitb_mem_pkg.sv
// Shared state encoding, default sizing and byte-lane semantics for the
// iiitb data-memory responder.
package iiitb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_LATENCY = 2;

  // Lane i of the result comes from new_word when be[i] is set, else old_word.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/iiitb_sp_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Each byte lane is its own array so the lanes map onto block-RAM byte writes.
module iiitb_sp_ram
  import iiitb_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_reg;

      // Read data only moves when en is set, so it holds while a response waits.
      always_ff @(posedge clk) begin
        if (en) begin
          if (we && be[gi]) mem[addr] <= wdata[8*gi +: 8];
          rd_reg <= mem[addr];
        end
      end

      assign rdata[8*gi +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/iiitb_dmem_resp.sv
// Data-memory responder: one outstanding request, fixed wait latency, then a
// response held until the initiator takes it. Out-of-range addresses report rsp_err.
module iiitb_dmem_resp
  import iiitb_mem_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        RN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  be_reg;

  logic        accept;
  logic        enter_resp;
  logic        op_we;
  logic [31:0] op_addr, op_wdata;
  logic [3:0]  op_be;
  logic        op_in_range;
  logic        ram_en, ram_we;
  logic [31:0] ram_rdata;
  logic        rsp_in_range;

  assign req_ready = (state_reg == IDLE) && !RN;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (RN) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg    <= req_we;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      be_reg    <= req_be;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero latency the RAM is touched on the accept edge itself, before the
  // request registers are loaded, so the live request feeds the RAM from IDLE.
  assign op_we       = (state_reg == IDLE) ? req_we    : we_reg;
  assign op_addr     = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign op_wdata    = (state_reg == IDLE) ? req_wdata : wdata_reg;
  assign op_be       = (state_reg == IDLE) ? req_be    : be_reg;
  assign op_in_range = op_addr < DEPTH_W;

  assign ram_en = enter_resp && op_in_range && !RN;
  assign ram_we = ram_en && op_we;

  iiitb_sp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (op_addr[AW-1:0]),
    .wdata (op_wdata),
    .be    (op_be),
    .rdata (ram_rdata)
  );

  assign rsp_in_range = addr_reg < DEPTH_W;
  assign rsp_valid    = (state_reg == RESP) && !RN;
  assign rsp_err      = rsp_valid && !rsp_in_range;
  assign rsp_rdata    = (rsp_valid && rsp_in_range && !we_reg) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_iiitb_dmem_resp.sv
// Scoreboard bench for iiitb_dmem_resp: a LATENCY=2 instance under directed and
// random traffic, and a LATENCY=0 instance streaming back-to-back requests.
module tb_iiitb_dmem_resp;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rn, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        rn1, req_valid1, req_ready1, req_we1, rsp_valid1, rsp_err1;
  logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [3:0]  req_be1;

  iiitb_dmem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .RN(rn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  iiitb_dmem_resp #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .RN(rn1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .rsp_valid(rsp_valid1), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] model0 [DEPTH];
  logic [31:0] model1 [DEPTH];
  bit          written0 [DEPTH];

  int vectors = 0;
  int errors  = 0;
  bit rand_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: a word array with byte-lane stores and range checking.
  task automatic predict(input int inst, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output logic [31:0] rd, output logic er);
    logic [31:0] w;
    rd = 32'd0;
    er = (a >= DEPTH);
    if (!er) begin
      w = (inst == 0) ? model0[a[5:0]] : model1[a[5:0]];
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        if (inst == 0) begin
          model0[a[5:0]]   = w;
          written0[a[5:0]] = 1'b1;
        end else begin
          model1[a[5:0]] = w;
        end
      end else begin
        rd = w;
      end
    end
  endtask

  task automatic issue0(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit push);
    int n = 0;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: req_ready=0 after %0d cycles, required 1", n);
      req_valid = 1'b0;
      return;
    end
    if (push) begin
      predict(0, we, a, d, be, rd, er);
      q0.push_back('{rd, er, cyc, 1'b0});
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle0();
    int n = 0;
    @(negedge clk);
    while ((q0.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      errors++;
      $display("FAIL idle_timeout: queue depth %0d, required 0", q0.size());
    end
  endtask

  // Monitor for the LATENCY=2 instance: data must match and stay put until taken.
  always @(negedge clk) begin
    if (!rn && rsp_valid) begin
      if (q0.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h, required no response", rsp_rdata);
      end else begin
        if (!q0[0].seen) begin
          chk("rsp_latency", 32'(cyc - q0[0].acc), 32'(LAT + 1));
          q0[0].seen = 1'b1;
        end
        chk("rsp_rdata", rsp_rdata, q0[0].rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, q0[0].err});
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        if (rsp_ready) void'(q0.pop_front());
      end
    end
  end

  // Monitor for the LATENCY=0 instance (rsp_ready tied high).
  always @(negedge clk) begin
    if (!rn1 && rsp_valid1) begin
      if (q1.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_rsp_l0: rsp_valid=1 rdata=%h, required no response", rsp_rdata1);
      end else begin
        chk("l0_latency", 32'(cyc - q1[0].acc), 32'd1);
        chk("l0_rdata", rsp_rdata1, q1[0].rdata);
        chk("l0_err", {31'd0, rsp_err1}, {31'd0, q1[0].err});
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rn = 1'b1; rn1 = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0;
    rand_done = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1 rn = 1'b0; rn1 = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Full and partial stores, zero-enable store, range errors and the top word.
    issue0(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    issue0(1'b0, 32'd5, 32'd0, 4'h0, 1'b1);
    issue0(1'b1, 32'd5, 32'h11223344, 4'b0101, 1'b1);
    issue0(1'b0, 32'd5, 32'd0, 4'h0, 1'b1);
    issue0(1'b0, 32'd64, 32'd0, 4'h0, 1'b1);
    issue0(1'b0, 32'hFFFF_FFC5, 32'd0, 4'h0, 1'b1);
    issue0(1'b1, 32'd69, 32'hCAFEF00D, 4'hF, 1'b1);
    issue0(1'b0, 32'd5, 32'd0, 4'h0, 1'b1);
    issue0(1'b1, 32'd5, 32'h99999999, 4'b0000, 1'b1);
    issue0(1'b0, 32'd5, 32'd0, 4'h0, 1'b1);
    issue0(1'b1, 32'd63, 32'h0BADCAFE, 4'hF, 1'b1);
    issue0(1'b0, 32'd63, 32'd0, 4'h0, 1'b1);

    // Response back-pressure: outputs hold, a new request is not taken.
    wait_idle0();
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    issue0(1'b0, 32'd5, 32'd0, 4'h0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'h0; req_be = 4'hF;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      if (i < 4) @(negedge clk);
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue0(1'b0, 32'd5, 32'd0, 4'h0, 1'b1);

    // Reset one cycle into a store: it must be abandoned.
    issue0(1'b1, 32'd7, 32'h01234567, 4'hF, 1'b1);
    issue0(1'b0, 32'd7, 32'd0, 4'h0, 1'b1);
    wait_idle0();
    issue0(1'b1, 32'd7, 32'hA5A5A5A5, 4'hF, 1'b0);
    rn = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk);
    #1 rn = 1'b0;
    @(negedge clk);
    chk("after_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("after_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    issue0(1'b0, 32'd7, 32'd0, 4'h0, 1'b1);
    wait_idle0();

    // Random traffic with random response back-pressure.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic        rwe;
          logic [31:0] ra, rd;
          logic [3:0]  rbe;
          rwe = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 7))
            0:       ra = 32'(DEPTH) + 32'($urandom_range(0, 255));
            1:       ra = $urandom | 32'h8000_0000;
            default: ra = 32'($urandom_range(0, DEPTH - 1));
          endcase
          rd  = $urandom;
          rbe = 4'($urandom_range(0, 15));
          if (ra < DEPTH && !written0[ra[5:0]]) begin
            rwe = 1'b1;
            rbe = 4'hF;
          end
          issue0(rwe, ra, rd, rbe, 1'b1);
        end
        wait_idle0();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
    join

    // LATENCY=0 instance: request held high, one transaction every 2 cycles.
    begin
      int          last;
      logic [31:0] a1, d1, rd1;
      logic        er1;
      last = 0;
      @(negedge clk);
      for (int k = 0; k < 17; k++) begin
        a1 = (k < 8) ? 32'(k) : ((k < 16) ? 32'(15 - k) : 32'd64);
        d1 = $urandom;
        req_valid1 = 1'b1; req_we1 = (k < 8); req_addr1 = a1; req_wdata1 = d1; req_be1 = 4'hF;
        n = 0;
        while (!req_ready1 && n < 20) begin
          @(negedge clk);
          n++;
        end
        if (!req_ready1) begin
          vectors++;
          errors++;
          $display("FAIL l0_accept_timeout: req_ready=0, required 1");
          break;
        end
        if (k > 0) chk("l0_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        predict(1, (k < 8), a1, d1, 4'hF, rd1, er1);
        q1.push_back('{rd1, er1, cyc, 1'b0});
        @(negedge clk);
      end
      req_valid1 = 1'b0;
      repeat (4) @(negedge clk);
      chk("l0_queue_empty", 32'(q1.size()), 32'd0);
    end

    wait_idle0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/iiitb_dmem_resp.md
IIITB_DMEM_RESP -- requirements
Module: iiitb_dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit data words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request accept and response valid (legal range 0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port RN  input  1  reset; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  word address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables; bit i covers bits [8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  address out of range (req_addr >= DEPTH).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request when req_valid & req_ready, capturing we, addr, wdata, be in that cycle.
REQ-017 On accept, SHALL move to WAIT with counter loaded to LATENCY-1, or directly to RESP when LATENCY = 0.
REQ-018 In WAIT, SHALL decrement the counter each cycle and enter RESP on the cycle after it reaches 0; rsp_valid SHALL therefore assert exactly LATENCY+1 cycles after the accept edge.
REQ-019 SHALL commit a store (byte lanes with be=1 only) and sample load data on the transition into RESP.
REQ-020 Out-of-range address: no array write, rsp_rdata = 0, rsp_err = 1; the full 32-bit address SHALL be compared, no wrap-around or truncation.
REQ-021 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready = 1; on that cycle the FSM SHALL return to IDLE.
REQ-022 A store with be = 4'b0000 SHALL complete normally with no data change.
REQ-023 req_valid while not in IDLE SHALL be ignored; the initiator holds the request until req_ready.
REQ-024 Maximum throughput SHALL be one transaction per LATENCY+2 cycles.

Reset
REQ-025 While RN = 1: state IDLE, counter 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-026 On the first cycle after RN deasserts: req_ready 1.
REQ-027 Reset mid-transaction SHALL abandon it; a store not yet committed per REQ-019 SHALL NOT be written.
REQ-028 The storage array is not reset; its contents SHALL be preserved across RN.

Structure
REQ-029 Package iiitb_mem_pkg SHALL hold the FSM state encoding, default DEPTH/LATENCY constants and the byte-lane merge function.
REQ-030 Storage SHALL be sub-module iiitb_sp_ram (single-port, synchronous write, per-byte enables).

Verification (DEPTH=64, LATENCY=2)
REQ-031 Store addr 5, data 32'hDEADBEEF, be 4'hF; then load addr 5 -> rsp_valid 3 cycles after each accept, load rdata 32'hDEADBEEF, err 0.
REQ-032 Store addr 5, data 32'h11223344, be 4'b0101; then load -> rdata 32'hDE22BE44.
REQ-033 Load addr 64 and addr 32'hFFFF_FFC5 -> rsp_err 1, rdata 0, addr 5 still reads 32'hDE22BE44.
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_valid and data stable for all 5 cycles, req_ready 0, a new req_valid is not accepted.
REQ-035 RN pulsed 1 cycle after accepting store addr 7 data 32'hA5A5A5A5 -> outputs per REQ-025; later load addr 7 returns its prior value.
REQ-036 LATENCY=0 instance, back-to-back loads with rsp_ready tied 1 -> one response every 2 cycles.
